spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) facing the external host.
//  Sits directly upstream of the packet controller: delivers each received byte
//  with a 1-cycle strobe, and pulses a transaction-start flag on chip-select assertion.
//  Shifts the controller's reply byte out on MISO.
//  All SPI pins are asynchronous to clk and are synchronised internally.
// PARAMETERS
//  SYNC_STAGES  2  flops in each pin synchroniser (sck, cs_n, mosi); legal >= 2
// PORTS
//  clk            in   1  system clock
//  rst            in   1  reset, synchronous, active-high
//  spi_sck        in   1  SPI clock from host (async)
//  spi_cs_n       in   1  SPI chip select from host, active-low (async)
//  spi_mosi       in   1  SPI data host->slave (async)
//  spi_miso       out  1  SPI data slave->host; equals tx_sr[7]
//  spi_miso_oe    out  1  MISO output enable; 1 while synced cs_n is low
//  spi_c_data_in  in   8  reply byte from controller, loaded at byte boundary
//  spi_c_data_out out  8  last received byte; held until next byte completes
//  spi_c_data_stb out  1  1-cycle pulse: spi_c_data_out valid (new) this cycle
//  spi_tsx_start  out  1  1-cycle pulse on synced cs_n falling edge
//  spi_frame_err  out  1  1-cycle pulse: cs_n deasserted with partial byte
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit_cnt=0; tx_sr=0; rx_sr=0.
//  Reset: synchroniser chains preset to idle levels (sck=0, cs_n=1, mosi=0),
//   so no spurious edge is seen on exit from reset.
//  Sync: sck/cs_n/mosi each pass SYNC_STAGES flops (same depth, so aligned).
//   Sync is followed by one prev-flop for edge detect.
//   rise = sck_s & ~sck_p; fall = ~sck_s & sck_p; cs_fall = ~cs_s & cs_p.
//  FSM states:
//   IDLE: miso_oe=0, bit_cnt=0.
//    On cs_fall: tsx_start<=1 (next cycle), state<=ACTIVE.
//   ACTIVE, cs_s=1 (deassert): state<=IDLE, bit_cnt<=0, rx_sr discarded.
//    If bit_cnt!=0: frame_err<=1. No stb for the partial byte.
//   ACTIVE, rise: rx_sr<={rx_sr[6:0],mosi_s}; bit_cnt<=bit_cnt+1 (3-bit).
//    If bit_cnt==7: spi_c_data_out<={rx_sr[6:0],mosi_s}; stb<=1; bit_cnt wraps to 0.
//   ACTIVE, fall with bit_cnt!=0: tx_sr<={tx_sr[6:0],1'b0}.
//   ACTIVE, bit_cnt==0 and sck_s==0: tx_sr<=spi_c_data_in every cycle (transparent load).
//    Controller updates to the reply after tsx_start/stb therefore reach MISO
//    before the byte's first rising edge.
//  Rise and fall are mutually exclusive by construction.
//   cs deassert takes priority over a same-cycle rise.
//  A cs_fall while already ACTIVE is impossible; a cs glitch shorter than the
//   sync window may be missed (acceptable).
//  Latency:
//   tsx_start high SYNC_STAGES+1 clk after the first clk edge sampling cs_n low.
//   stb high SYNC_STAGES+1 clk after the first clk edge sampling the 8th sck high.
//  Timing requirement: sck high and low phases each >= SYNC_STAGES+2 clk periods.
//   Therefore stb pulses are >= 16 clk apart.
//   This meets the controller's rule of at most 1 stb per 3 cycles.
//  Bytes stream back-to-back within one cs assertion with no gap required.
//   Each completed byte gives exactly one stb.
//  rst mid-transfer: immediate return to IDLE; partial byte dropped; no frame_err.
//   The next byte requires a fresh cs_n falling edge.
// TESTING
//  1. Reset, then cs_n low -> exactly one tsx_start pulse, SYNC_STAGES+1 clk
//     after sampling; miso_oe=1.
//  2. spi_c_data_in=8'hA5; host clocks MOSI 8'h01 (sck 4 clk high / 4 clk low)
//     -> MISO bits 1,0,1,0,0,1,0,1; one stb with data_out=8'h01.
//  3. Three back-to-back bytes 8'h02,8'h10,8'hFF under one cs -> 3 stb, in order,
//     each >=16 clk apart; data_out held between stb.
//  4. cs_n high after 5 sck rises -> frame_err pulse, no stb. Next cs frame
//     byte 8'h3C -> stb with 8'h3C (no leftover bits).
//  5. rst asserted after 3 sck rises -> outputs 0, state IDLE. New frame byte
//     8'hC3 received correctly.
//  6. Random SCK jitter within timing rule, 256 random bytes -> received stream
//     equals sent stream; MISO equals loaded replies.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) feeding the packet controller.
// SPI pins are synchronised into clk; bytes are delivered with a 1-cycle strobe.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] spi_c_data_in,
    output logic [7:0] spi_c_data_out,
    output logic       spi_c_data_stb,
    output logic       spi_tsx_start,
    output logic       spi_frame_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_p;
    logic                   cs_p;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   fall;
    logic                   cs_fall;

    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;

    // Chains preset to idle pin levels so leaving reset never looks like an edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_p     <= 1'b0;
            cs_p      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_p     <= sck_s;
            cs_p      <= cs_s;
        end
    end

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sck_s & ~sck_p;
    assign fall    = ~sck_s & sck_p;
    assign cs_fall = ~cs_s & cs_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_s)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_miso    = tx_sr[7];
        spi_miso_oe = 1'b0;
        if (state == ACTIVE && !cs_s) begin
            spi_miso_oe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt        <= 3'd0;
            rx_sr          <= 8'h00;
            tx_sr          <= 8'h00;
            spi_c_data_out <= 8'h00;
            spi_c_data_stb <= 1'b0;
            spi_tsx_start  <= 1'b0;
            spi_frame_err  <= 1'b0;
        end else begin
            spi_c_data_stb <= 1'b0;
            spi_tsx_start  <= 1'b0;
            spi_frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    if (cs_fall) begin
                        spi_tsx_start <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_s) begin
                        // Deselect wins over a same-cycle rise; a partial byte is dropped.
                        bit_cnt       <= 3'd0;
                        rx_sr         <= 8'h00;
                        spi_frame_err <= (bit_cnt != 3'd0);
                    end else if (rise) begin
                        rx_sr   <= {rx_sr[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            spi_c_data_out <= {rx_sr[6:0], mosi_s};
                            spi_c_data_stb <= 1'b1;
                        end
                    end else if (fall && bit_cnt != 3'd0) begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end else if (bit_cnt == 3'd0 && !sck_s) begin
                        // Transparent load until the byte's first rise, so late replies still make it.
                        tx_sr <= spi_c_data_in;
                    end
                end
                default: bit_cnt <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a host model drives SCK/CS/MOSI and collects MISO,
// a negedge monitor logs strobes and pulses, and check() compares against hand values.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] spi_c_data_in;
    logic [7:0] spi_c_data_out;
    logic       spi_c_data_stb;
    logic       spi_tsx_start;
    logic       spi_frame_err;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_sck        (spi_sck),
        .spi_cs_n       (spi_cs_n),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_miso_oe    (spi_miso_oe),
        .spi_c_data_in  (spi_c_data_in),
        .spi_c_data_out (spi_c_data_out),
        .spi_c_data_stb (spi_c_data_stb),
        .spi_tsx_start  (spi_tsx_start),
        .spi_frame_err  (spi_frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;

    // Monitor state, written only by the negedge monitor process.
    logic [7:0] stb_q[$];
    int         stb_cyc[$];
    int         tsx_cnt = 0;
    int         tsx_cyc = 0;
    int         ferr_cnt = 0;
    int         hold_viol = 0;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            last_data <= spi_c_data_out;
        end else begin
            if (spi_c_data_stb) begin
                stb_q.push_back(spi_c_data_out);
                stb_cyc.push_back(cyc);
                last_data <= spi_c_data_out;
            end else if (spi_c_data_out !== last_data) begin
                hold_viol <= hold_viol + 1;
            end
            if (spi_tsx_start) begin
                tsx_cnt <= tsx_cnt + 1;
                tsx_cyc <= cyc;
            end
            if (spi_frame_err) ferr_cnt <= ferr_cnt + 1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks and land 1 time unit after the posedge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host side of one byte: nbits MSB-first bits, random phase lengths in [4, max].
    task automatic send_byte(input logic [7:0] tx, input logic [7:0] reply, input int nbits,
                             input int lo_max, input int hi_max, output logic [7:0] mb);
        int lo;
        int hi;
        mb = 8'h00;
        spi_c_data_in = reply;
        for (int i = 0; i < nbits; i++) begin
            lo = int'($urandom_range(lo_max, 4));
            hi = int'($urandom_range(hi_max, 4));
            spi_mosi = tx[7-i];
            tick(lo);
            mb[7-i] = spi_miso;
            spi_sck = 1'b1;
            last_rise = cyc;
            tick(hi);
            spi_sck = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data_out"}, {24'h0, spi_c_data_out}, 32'h00);
        check({tag, "_stb"}, {31'h0, spi_c_data_stb}, 32'h0);
        check({tag, "_tsx"}, {31'h0, spi_tsx_start}, 32'h0);
        check({tag, "_ferr"}, {31'h0, spi_frame_err}, 32'h0);
        check({tag, "_miso"}, {31'h0, spi_miso}, 32'h0);
        check({tag, "_oe"}, {31'h0, spi_miso_oe}, 32'h0);
    endtask

    task automatic open_frame();
        spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic close_frame();
        spi_cs_n = 1'b1;
        tick(6);
    endtask

    logic [7:0] mb;
    logic [7:0] tx_b;
    logic [7:0] rp_b;
    int         t0;
    int         ferr0;
    int         tsx0;
    logic [7:0] t3_data[3]  = '{8'h02, 8'h10, 8'hFF};
    logic [7:0] t3_reply[3] = '{8'h5A, 8'hC3, 8'h81};

    initial begin
        rst = 1'b1;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        spi_c_data_in = 8'h00;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(4);
        check("no_spurious_tsx", tsx_cnt, 0);

        // 1: transaction start latency
        spi_cs_n = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 10 && tsx_cnt == 0; i++) tick(1);
        tick(4);
        check("tsx_count", tsx_cnt, 1);
        check("tsx_latency", tsx_cyc - t0, 3);
        check("miso_oe_active", {31'h0, spi_miso_oe}, 32'h1);

        // 2: single byte, reply A5
        send_byte(8'h01, 8'hA5, 8, 4, 4, mb);
        tick(2);
        check("t2_miso", {24'h0, mb}, 32'hA5);
        check("t2_stb_count", stb_q.size(), 1);
        if (stb_q.size() > 0) begin
            check("t2_data", {24'h0, stb_q[0]}, 32'h01);
            check("t2_stb_latency", stb_cyc[0] - last_rise, 3);
        end
        check("t2_data_out_held", {24'h0, spi_c_data_out}, 32'h01);

        // 3: three back-to-back bytes
        stb_q.delete();
        stb_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            send_byte(t3_data[i], t3_reply[i], 8, 4, 4, mb);
            check("t3_miso", {24'h0, mb}, {24'h0, t3_reply[i]});
        end
        tick(2);
        check("t3_stb_count", stb_q.size(), 3);
        if (stb_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("t3_data", {24'h0, stb_q[i]}, {24'h0, t3_data[i]});
            check("t3_gap01", {31'h0, (stb_cyc[1] - stb_cyc[0]) >= 16}, 32'h1);
            check("t3_gap12", {31'h0, (stb_cyc[2] - stb_cyc[1]) >= 16}, 32'h1);
        end
        close_frame();

        // 4: partial byte then deselect, next frame clean
        stb_q.delete();
        ferr0 = ferr_cnt;
        open_frame();
        send_byte(8'hF8, 8'h00, 5, 4, 4, mb);
        tick(2);
        close_frame();
        check("t4_frame_err", ferr_cnt - ferr0, 1);
        check("t4_no_stb", stb_q.size(), 0);
        open_frame();
        send_byte(8'h3C, 8'h96, 8, 4, 4, mb);
        tick(2);
        check("t4_miso", {24'h0, mb}, 32'h96);
        check("t4_stb_count", stb_q.size(), 1);
        if (stb_q.size() > 0) check("t4_data", {24'h0, stb_q[0]}, 32'h3C);
        close_frame();

        // 5: reset mid-transfer
        stb_q.delete();
        ferr0 = ferr_cnt;
        open_frame();
        send_byte(8'hE0, 8'hFF, 3, 4, 4, mb);
        rst = 1'b1;
        tick(2);
        check_idle_outputs("t5_rst");
        spi_cs_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        check("t5_no_ferr", ferr_cnt - ferr0, 0);
        check("t5_no_stb", stb_q.size(), 0);
        tsx0 = tsx_cnt;
        open_frame();
        check("t5_tsx", tsx_cnt - tsx0, 1);
        send_byte(8'hC3, 8'h3A, 8, 4, 4, mb);
        tick(2);
        check("t5_miso", {24'h0, mb}, 32'h3A);
        check("t5_stb_count", stb_q.size(), 1);
        if (stb_q.size() > 0) check("t5_data", {24'h0, stb_q[0]}, 32'hC3);

        // 6: 256 random bytes with jittered phases
        stb_q.delete();
        for (int i = 0; i < 256; i++) begin
            tx_b = 8'($urandom());
            rp_b = 8'($urandom());
            send_byte(tx_b, rp_b, 8, 7, 7, mb);
            check("t6_miso", {24'h0, mb}, {24'h0, rp_b});
            if (stb_q.size() != 1) begin
                check("t6_stb_count", stb_q.size(), 1);
                stb_q.delete();
            end else begin
                check("t6_data", {24'h0, stb_q.pop_front()}, {24'h0, tx_b});
            end
        end
        close_frame();
        check("t6_no_ferr", ferr_cnt - ferr0, 0);
        check("data_out_hold", hold_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
